// File: rtl/splitr.sv
// splitr: one-to-two stream fork, each branch buffered by its own DEPTH-entry FIFO.
// Latency: 1 cycle from input acceptance to valid on both branches (no bypass).
// Backpressure: ready_out drops when either branch FIFO is full (registered counts only).
//
// Ports (splitr):
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   data/valid/last       input beat; ready_out accepts it
//   data_k/valid_k/last_k branch k head-of-FIFO beat; ready_k pops it
//   cnt_k                 branch k FIFO occupancy

// splitr_fifo: small synchronous FIFO holding one branch of the fork.
// Latency: 1 cycle push-to-head; head held stable until popped.
// Backpressure: caller must not push when full; pop on empty is ignored.
module splitr_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [W-1:0]               dat_i,
    input  logic                       pop_i,
    output logic [W-1:0]               dat_o,
    output logic                       vld_o,
    output logic [$clog2(DEPTH):0]     cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pop;

    // Popping an empty FIFO is a no-op; the consumer's ready is ignored then.
    assign pop = pop_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Push and pop together leave the occupancy unchanged.
        if (push_i && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !push_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= dat_i;
            end
        end
    end

    assign dat_o = mem_q[rd_ptr_q];
    assign vld_o = (cnt_q != '0);
    assign cnt_o = cnt_q;
endmodule

module splitr #(
    parameter int LEN   = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN-1:0]             data,
    input  logic                       valid,
    input  logic                       last,
    output logic                       ready_out,
    output logic [LEN-1:0]             data_0,
    output logic                       valid_0,
    output logic                       last_0,
    input  logic                       ready_0,
    output logic [LEN-1:0]             data_1,
    output logic                       valid_1,
    output logic                       last_1,
    input  logic                       ready_1,
    output logic [$clog2(DEPTH):0]     cnt_0,
    output logic [$clog2(DEPTH):0]     cnt_1
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic           last;
        logic [LEN-1:0] dat;
    } beat_t;

    beat_t in_beat, out_beat_0, out_beat_1;
    logic  push;

    // Only registered counts feed ready_out: a full FIFO being popped this
    // cycle still blocks, keeping ready_k off the input-side timing path.
    assign ready_out = (cnt_0 != FULL) && (cnt_1 != FULL);
    // One push enable drives both FIFOs so a beat is never delivered to one branch only.
    assign push      = valid && ready_out;
    assign in_beat   = '{last: last, dat: data};

    splitr_fifo #(.W(LEN + 1), .DEPTH(DEPTH)) u_fifo_0 (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .dat_i  (in_beat),
        .pop_i  (ready_0),
        .dat_o  (out_beat_0),
        .vld_o  (valid_0),
        .cnt_o  (cnt_0)
    );

    splitr_fifo #(.W(LEN + 1), .DEPTH(DEPTH)) u_fifo_1 (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .dat_i  (in_beat),
        .pop_i  (ready_1),
        .dat_o  (out_beat_1),
        .vld_o  (valid_1),
        .cnt_o  (cnt_1)
    );

    assign data_0 = out_beat_0.dat;
    assign last_0 = out_beat_0.last;
    assign data_1 = out_beat_1.dat;
    assign last_1 = out_beat_1.last;
endmodule

// File: tb/tb_splitr.sv
// tb_splitr: scoreboard bench for the splitr stream fork.
// Latency: n/a (bench); expects 1-cycle push-to-valid on both branches.
// Backpressure: drives ready_0/ready_1 fixed, stalled, and pseudo-random.
module tb_splitr;
    localparam int LEN   = 8;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int TMO   = 200;

    logic           clk;
    logic           rst;
    logic [LEN-1:0] data;
    logic           valid;
    logic           last;
    logic           ready_out;
    logic [LEN-1:0] data_0, data_1;
    logic           valid_0, valid_1;
    logic           last_0, last_1;
    logic           ready_0, ready_1;
    logic [CW-1:0]  cnt_0, cnt_1;

    int errs   = 0;
    int checks = 0;
    int pops0  = 0;
    int pops1  = 0;

    logic [LEN:0] q0[$];
    logic [LEN:0] q1[$];

    logic        rand_rdy = 1'b0;
    logic [15:0] lfsr     = 16'hACE1;

    splitr #(.LEN(LEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .valid     (valid),
        .last      (last),
        .ready_out (ready_out),
        .data_0    (data_0),
        .valid_0   (valid_0),
        .last_0    (last_0),
        .ready_0   (ready_0),
        .data_1    (data_1),
        .valid_1   (valid_1),
        .last_1    (last_1),
        .ready_1   (ready_1),
        .cnt_0     (cnt_0),
        .cnt_1     (cnt_1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge: the values seen here are
    // what the DUT acts on at the next rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            q0.delete();
            q1.delete();
        end else begin
            chk("cnt0", 32'(cnt_0), q0.size());
            chk("cnt1", 32'(cnt_1), q1.size());
            chk("cnt0_range", 32'(cnt_0 <= CW'(DEPTH)), 1);
            chk("cnt1_range", 32'(cnt_1 <= CW'(DEPTH)), 1);
            chk("vld0", 32'(valid_0), 32'(q0.size() != 0));
            chk("vld1", 32'(valid_1), 32'(q1.size() != 0));
            chk("rdy_out", 32'(ready_out), 32'(q0.size() < DEPTH && q1.size() < DEPTH));
            if (valid_0 && q0.size() != 0) begin
                chk("head0", 32'({last_0, data_0}), 32'(q0[0]));
                if (ready_0) begin
                    void'(q0.pop_front());
                    pops0++;
                end
            end
            if (valid_1 && q1.size() != 0) begin
                chk("head1", 32'({last_1, data_1}), 32'(q1[0]));
                if (ready_1) begin
                    void'(q1.pop_front());
                    pops1++;
                end
            end
            if (valid && ready_out) begin
                q0.push_back({last, data});
                q1.push_back({last, data});
            end
        end
    end

    // Pseudo-random consumer readiness, fixed seed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                ready_0 = lfsr[0];
                ready_1 = lfsr[5];
            end
        end
    end

    // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
    task automatic send(input logic [LEN-1:0] d, input logic l);
        int n;
        n     = 0;
        valid = 1'b1;
        data  = d;
        last  = l;
        @(negedge clk);
        while (!ready_out && n < TMO) begin
            n++;
            @(negedge clk);
        end
        if (n >= TMO) chk("send_timeout", n, 0);
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((q0.size() != 0 || q1.size() != 0) && n < TMO) begin
            n++;
            @(negedge clk);
        end
        if (n >= TMO) chk("drain_timeout", n, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        valid   = 1'b1;
        data    = 8'h5A;
        last    = 1'b0;
        ready_0 = 1'b0;
        ready_1 = 1'b0;

        // 1. Reset held with valid high: nothing buffered.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld0", valid_0, 0);
        chk("rst_vld1", valid_1, 0);
        chk("rst_cnt0", cnt_0, 0);
        chk("rst_cnt1", cnt_1, 0);
        chk("rst_dat0", data_0, 0);
        rst = 1'b1;
        #1;
        chk("rel_rdy", ready_out, 1);
        chk("rel_vld0", valid_0, 0);
        chk("rel_cnt1", cnt_1, 0);
        valid = 1'b0;
        @(posedge clk);
        #1;

        // 2. Broadcast with both consumers ready.
        ready_0 = 1'b1;
        ready_1 = 1'b1;
        send(8'h11, 1'b0);
        chk("lat_vld0", valid_0, 1);
        chk("lat_vld1", valid_1, 1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        drain();
        chk("bc_pops0", pops0, 3);
        chk("bc_pops1", pops1, 3);

        // 3. Branch 1 stalled while streaming.
        ready_1 = 1'b0;
        fork
            begin
                for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                chk("stall_cnt1", cnt_1, 2);
                chk("stall_rdy", ready_out, 0);
                ready_1 = 1'b1;
            end
        join
        drain();
        chk("stall_pops0", pops0, 8);
        chk("stall_pops1", pops1, 8);

        // 4. Full FIFO popped in the same cycle still blocks input.
        ready_0 = 1'b0;
        send(8'h41, 1'b0);
        send(8'h42, 1'b0);
        chk("full_cnt0", cnt_0, 2);
        ready_0 = 1'b1;
        valid   = 1'b1;
        data    = 8'h77;
        last    = 1'b1;
        @(negedge clk);
        chk("full_pop_rdy", ready_out, 0);
        chk("full_pop_cnt0", cnt_0, 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_pop_cnt0", cnt_0, 1);
        chk("after_pop_rdy", ready_out, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("pushpop_cnt0", cnt_0, 1);
        drain();
        chk("full_pops0", pops0, 11);
        chk("full_pops1", pops1, 11);

        // 5. Wrap-around with random consumer readiness.
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) send(8'(i), i == 19);
        rand_rdy = 1'b0;
        ready_0  = 1'b1;
        ready_1  = 1'b1;
        drain();
        chk("rand_pops0", pops0, 31);
        chk("rand_pops1", pops1, 31);

        // 6. Asynchronous reset mid-operation discards buffered beats.
        ready_0 = 1'b0;
        ready_1 = 1'b0;
        send(8'h51, 1'b0);
        send(8'h52, 1'b0);
        ready_1 = 1'b1;
        @(posedge clk);
        #1;
        ready_1 = 1'b0;
        chk("pre_rst_cnt0", cnt_0, 2);
        chk("pre_rst_cnt1", cnt_1, 1);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_vld0", valid_0, 0);
        chk("arst_vld1", valid_1, 0);
        chk("arst_cnt0", cnt_0, 0);
        chk("arst_cnt1", cnt_1, 0);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        ready_0 = 1'b1;
        ready_1 = 1'b1;
        send(8'hAA, 1'b1);
        chk("post_rst_dat0", data_0, 8'hAA);
        chk("post_rst_dat1", data_1, 8'hAA);
        chk("post_rst_last0", last_0, 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
